// File: rtl/fifo_wr_arbiter_pkg.sv
// rtl/fifo_wr_arbiter_pkg.sv - shared types and width helpers for the write-port arbiter
//
// Contents:
//   arb_state_t : arbiter FSM state (IDLE = free arbitration, LOCK = burst owner holds the port)
//   clog2       : ceiling log2, usable in parameter context
//   ptrw        : width of a requester index (never below 1 bit)
package fifo_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } arb_state_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) begin
         r++;
      end
      return r;
   endfunction

   // Sizes pointer/owner registers; a single requester still needs one bit.
   function automatic int ptrw(input int n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - producer/buffer write-side bundle for the arbiter
//
// Signals:
//   Req      : per-requester write request (level, held until granted)
//   Reqdata  : packed request words, requester i at [i*WIDTH +: WIDTH]
//   Full     : buffer full flag
//   Gnt      : one-hot grant, word consumed in the same cycle
//   Wren     : buffer write enable
//   Datain   : buffer write data
//   Owner    : index of the last granted requester (registered)
//   Stallcnt : saturating count of cycles with pending requests while full
// Modports:
//   master : producer/buffer side (drives Req, Reqdata, Full)
//   slave  : arbiter side
interface fifo_wr_arbiter_if
   import fifo_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 32,
   parameter int CNTW  = 16
);

   localparam int PTRW = ptrw(NREQ);

   logic [NREQ-1:0]       Req;
   logic [NREQ*WIDTH-1:0] Reqdata;
   logic                  Full;
   logic [NREQ-1:0]       Gnt;
   logic                  Wren;
   logic [WIDTH-1:0]      Datain;
   logic [PTRW-1:0]       Owner;
   logic [CNTW-1:0]       Stallcnt;

   modport master (
      output Req, Reqdata, Full,
      input  Gnt, Wren, Datain, Owner, Stallcnt
   );

   modport slave (
      input  Req, Reqdata, Full,
      output Gnt, Wren, Datain, Owner, Stallcnt
   );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational rotate-priority encoder
//
// Ports:
//   req    : request vector
//   ptr    : highest-priority index (must be < NREQ)
//   onehot : one-hot winner, zero when nothing is requested
//   idx    : winner index, zero when nothing is requested
//   any    : at least one request present
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int PTRW = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [PTRW-1:0] ptr,
   output logic [NREQ-1:0] onehot,
   output logic [PTRW-1:0] idx,
   output logic            any
);

   // Scan from the lowest priority back toward ptr so the last hit recorded
   // is the first requester at or after ptr in rotation order.
   always_comb begin
      int cand;
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      cand   = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         cand = int'(ptr) + k;
         if (cand >= NREQ) begin
            cand = cand - NREQ;
         end
         if (req[cand]) begin
            idx = PTRW'(cand);
            any = 1'b1;
         end
      end
      if (any) begin
         onehot[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin write-port arbiter with optional burst lock
//
// Ports:
//   Clk : write-domain clock (buffer write clock)
//   Rst : asynchronous active-low reset
//   bus : fifo_wr_arbiter_if.slave (Req/Reqdata/Full in, Gnt/Wren/Datain/Owner/Stallcnt out)
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 32,
   parameter int BURST = 2,
   parameter int CNTW  = 16
) (
   input  logic               Clk,
   input  logic               Rst,
   fifo_wr_arbiter_if.slave   bus
);

   localparam int PTRW = ptrw(NREQ);
   localparam int BCW  = clog2(BURST + 1);

   arb_state_t      state, state_n;
   logic [PTRW-1:0] ptr, ptr_n;
   logic [PTRW-1:0] owner, owner_n;
   logic [BCW-1:0]  bcnt, bcnt_n;
   logic [CNTW-1:0] stall;

   logic [PTRW-1:0] pick_ptr, pick_idx;
   logic [NREQ-1:0] pick_oh;
   logic            pick_any;
   logic            any_req;
   logic            lock_hold;
   logic [NREQ-1:0] gnt;
   logic [NREQ-1:0] gnt_out;
   logic [WIDTH-1:0] datain;

   function automatic logic [PTRW-1:0] inc_mod(input logic [PTRW-1:0] v);
      return (int'(v) == NREQ - 1) ? '0 : v + 1'b1;
   endfunction

   assign any_req   = |bus.Req;
   assign lock_hold = (state == LOCK) && bus.Req[owner] && (int'(bcnt) < BURST);

   // A lock that is not held any more (owner dropped its request) releases the
   // pointer past the owner in the same cycle, so arbitration starts there.
   assign pick_ptr = (state == LOCK) ? inc_mod(owner) : ptr;

   rr_pick #(
      .NREQ (NREQ),
      .PTRW (PTRW)
   ) u_pick (
      .req    (bus.Req),
      .ptr    (pick_ptr),
      .onehot (pick_oh),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      owner_n = owner;
      bcnt_n  = bcnt;
      gnt     = '0;
      if (!bus.Full) begin
         if (!any_req) begin
            state_n = IDLE;
            bcnt_n  = '0;
         end else if (lock_hold) begin
            gnt[owner] = 1'b1;
            bcnt_n     = bcnt + 1'b1;
            if (int'(bcnt) + 1 >= BURST) begin
               state_n = IDLE;
               ptr_n   = inc_mod(owner);
            end
         end else if (pick_any) begin
            gnt     = pick_oh;
            owner_n = pick_idx;
            bcnt_n  = BCW'(1);
            if (BURST > 1) begin
               state_n = LOCK;
               ptr_n   = pick_idx;
            end else begin
               state_n = IDLE;
               ptr_n   = inc_mod(pick_idx);
            end
         end
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state <= IDLE;
         ptr   <= '0;
         owner <= '0;
         bcnt  <= '0;
      end else begin
         state <= state_n;
         ptr   <= ptr_n;
         owner <= owner_n;
         bcnt  <= bcnt_n;
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         stall <= '0;
      end else if (bus.Full && any_req && (stall != {CNTW{1'b1}})) begin
         stall <= stall + 1'b1;
      end
   end

   // Reset forces the write side quiet even while requests are pending.
   assign gnt_out = Rst ? gnt : '0;

   always_comb begin
      datain = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_out[i]) begin
            datain = bus.Reqdata[i*WIDTH +: WIDTH];
         end
      end
   end

   assign bus.Gnt      = gnt_out;
   assign bus.Wren     = |gnt_out;
   assign bus.Datain   = datain;
   assign bus.Owner    = owner;
   assign bus.Stallcnt = stall;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
   import fifo_arb_pkg::*;

   localparam int NI = 3;
   localparam int W  = 16;

   localparam logic [7:0] SEQ_A0 [8] = '{8'h1, 8'h1, 8'h2, 8'h2, 8'h4, 8'h4, 8'h8, 8'h8};
   localparam logic [7:0] SEQ_A1 [8] = '{8'h1, 8'h2, 8'h4, 8'h8, 8'h1, 8'h2, 8'h4, 8'h8};
   localparam logic [7:0] SEQ_A2 [8] = '{8'h1, 8'h1, 8'h1, 8'h2, 8'h2, 8'h2, 8'h4, 8'h4};
   localparam logic [7:0] SEQ_B  [6] = '{8'h1, 8'h1, 8'h4, 8'h4, 8'h1, 8'h1};
   localparam int         OWN_B  [6] = '{0, 0, 2, 2, 0, 0};

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fifo_wr_arbiter_if #(.NREQ(4), .WIDTH(W), .CNTW(4))  bus0 ();
   fifo_wr_arbiter_if #(.NREQ(4), .WIDTH(W), .CNTW(16)) bus1 ();
   fifo_wr_arbiter_if #(.NREQ(3), .WIDTH(W), .CNTW(5))  bus2 ();

   fifo_wr_arbiter #(.NREQ(4), .WIDTH(W), .BURST(2), .CNTW(4))  dut0 (.Clk(clk), .Rst(rst_n), .bus(bus0));
   fifo_wr_arbiter #(.NREQ(4), .WIDTH(W), .BURST(1), .CNTW(16)) dut1 (.Clk(clk), .Rst(rst_n), .bus(bus1));
   fifo_wr_arbiter #(.NREQ(3), .WIDTH(W), .BURST(3), .CNTW(5))  dut2 (.Clk(clk), .Rst(rst_n), .bus(bus2));

   logic [7:0]   req_v  [NI];
   logic         full_v [NI];
   logic [W-1:0] dat    [NI][8];

   logic [7:0]   gnt_o  [NI];
   logic         wren_o [NI];
   logic [W-1:0] din_o  [NI];
   logic [7:0]   own_o  [NI];
   logic [15:0]  stl_o  [NI];

   assign bus0.Req  = req_v[0][3:0];
   assign bus1.Req  = req_v[1][3:0];
   assign bus2.Req  = req_v[2][2:0];
   assign bus0.Full = full_v[0];
   assign bus1.Full = full_v[1];
   assign bus2.Full = full_v[2];

   for (genvar i = 0; i < 4; i++) begin : g_d4
      assign bus0.Reqdata[i*W +: W] = dat[0][i];
      assign bus1.Reqdata[i*W +: W] = dat[1][i];
   end
   for (genvar i = 0; i < 3; i++) begin : g_d3
      assign bus2.Reqdata[i*W +: W] = dat[2][i];
   end

   assign gnt_o[0]  = {4'b0, bus0.Gnt};
   assign gnt_o[1]  = {4'b0, bus1.Gnt};
   assign gnt_o[2]  = {5'b0, bus2.Gnt};
   assign wren_o[0] = bus0.Wren;
   assign wren_o[1] = bus1.Wren;
   assign wren_o[2] = bus2.Wren;
   assign din_o[0]  = bus0.Datain;
   assign din_o[1]  = bus1.Datain;
   assign din_o[2]  = bus2.Datain;
   assign own_o[0]  = {6'b0, bus0.Owner};
   assign own_o[1]  = {6'b0, bus1.Owner};
   assign own_o[2]  = {6'b0, bus2.Owner};
   assign stl_o[0]  = {12'b0, bus0.Stallcnt};
   assign stl_o[1]  = bus1.Stallcnt;
   assign stl_o[2]  = {11'b0, bus2.Stallcnt};

   function automatic int n_of(input int k);
      return (k == 2) ? 3 : 4;
   endfunction
   function automatic int burst_of(input int k);
      return (k == 0) ? 2 : ((k == 1) ? 1 : 3);
   endfunction
   function automatic int cntw_of(input int k);
      return (k == 0) ? 4 : ((k == 1) ? 16 : 5);
   endfunction

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 40) begin
            $display("FAIL %s inst%0d time=%0t actual=%0h expected=%0h", name, k, $time, act, exp);
         end
      end
   endtask

   // Reference model: who currently holds a burst, how many words it has
   // written, where round-robin resumes, and the stall tally.
   int         m_ptr   [NI];
   int         m_owner [NI];
   int         m_cnt   [NI];
   int         m_stall [NI];
   bit         m_lock  [NI];
   logic [7:0] last_gnt[NI];
   bit         chk_en = 1'b0;

   function automatic int model_pick(input int k);
      int n;
      int start;
      n = n_of(k);
      if (m_lock[k] && req_v[k][m_owner[k]]) return m_owner[k];
      start = m_lock[k] ? (m_owner[k] + 1) % n : m_ptr[k];
      for (int j = 0; j < n; j++) begin
         if (req_v[k][(start + j) % n]) return (start + j) % n;
      end
      return -1;
   endfunction

   always @(negedge clk) begin
      int n;
      int w;
      logic [7:0]   eg;
      logic [W-1:0] ed;
      if (chk_en) begin
         for (int k = 0; k < NI; k++) begin
            if (!rst_n) begin
               chk("rst_gnt", k, 32'(gnt_o[k]), 32'h0);
               chk("rst_wren", k, 32'(wren_o[k]), 32'h0);
               chk("rst_datain", k, 32'(din_o[k]), 32'h0);
               chk("rst_owner", k, 32'(own_o[k]), 32'h0);
               chk("rst_stall", k, 32'(stl_o[k]), 32'h0);
               m_ptr[k]    = 0;
               m_owner[k]  = 0;
               m_cnt[k]    = 0;
               m_stall[k]  = 0;
               m_lock[k]   = 1'b0;
               last_gnt[k] = 8'h0;
            end else begin
               n  = n_of(k);
               w  = full_v[k] ? -1 : model_pick(k);
               eg = (w >= 0) ? 8'(1 << w) : 8'h0;
               ed = (w >= 0) ? dat[k][w] : '0;
               chk("gnt", k, 32'(gnt_o[k]), 32'(eg));
               chk("wren", k, 32'(wren_o[k]), 32'(eg != 8'h0));
               chk("datain", k, 32'(din_o[k]), 32'(ed));
               chk("owner", k, 32'(own_o[k]), 32'(m_owner[k]));
               chk("stallcnt", k, 32'(stl_o[k]), 32'(m_stall[k]));
               last_gnt[k] = eg;
               if (full_v[k]) begin
                  if (req_v[k] != 8'h0 && m_stall[k] < (1 << cntw_of(k)) - 1) m_stall[k]++;
               end else if (req_v[k] == 8'h0) begin
                  m_lock[k] = 1'b0;
                  m_cnt[k]  = 0;
               end else if (m_lock[k] && req_v[k][m_owner[k]]) begin
                  m_cnt[k]++;
                  if (m_cnt[k] == burst_of(k)) begin
                     m_lock[k] = 1'b0;
                     m_ptr[k]  = (w + 1) % n;
                  end
               end else begin
                  m_owner[k] = w;
                  m_cnt[k]   = 1;
                  if (burst_of(k) > 1) begin
                     m_lock[k] = 1'b1;
                     m_ptr[k]  = w;
                  end else begin
                     m_ptr[k] = (w + 1) % n;
                  end
               end
            end
         end
      end
   end

   task automatic do_reset();
      @(posedge clk);
      #1;
      for (int k = 0; k < NI; k++) begin
         req_v[k]  = 8'h0;
         full_v[k] = 1'b0;
      end
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int dens;
      int fullp;
      for (int k = 0; k < NI; k++) begin
         req_v[k]  = 8'h0;
         full_v[k] = 1'b0;
         for (int i = 0; i < 8; i++) dat[k][i] = W'($urandom);
      end
      rst_n  = 1'b0;
      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // All requesters active: pure round-robin and burst rotation.
      req_v[0] = 8'h0F;
      req_v[1] = 8'h0F;
      req_v[2] = 8'h07;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk("lit_rr_b2", 0, 32'(gnt_o[0]), 32'(SEQ_A0[c]));
         chk("lit_rr_b1", 1, 32'(gnt_o[1]), 32'(SEQ_A1[c]));
         chk("lit_rr_b3", 2, 32'(gnt_o[2]), 32'(SEQ_A2[c]));
         chk("lit_rr_wren", 1, 32'(wren_o[1]), 32'h1);
      end

      // Two bursting requesters alternate; Owner trails the grant by a cycle.
      do_reset();
      req_v[0] = 8'h05;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         if (c < 6) chk("lit_burst_gnt", 0, 32'(gnt_o[0]), 32'(SEQ_B[c]));
         if (c >= 1) chk("lit_burst_owner", 0, 32'(own_o[0]), 32'(OWN_B[c-1]));
      end

      // Owner drops mid-burst: same-cycle handover, then pointer moves past 1.
      do_reset();
      req_v[0] = 8'h03;
      @(negedge clk);
      chk("lit_drop_first", 0, 32'(gnt_o[0]), 32'h1);
      @(posedge clk);
      #1;
      req_v[0] = 8'h02;
      @(negedge clk);
      chk("lit_drop_handover", 0, 32'(gnt_o[0]), 32'h2);
      @(negedge clk);
      chk("lit_drop_burst2", 0, 32'(gnt_o[0]), 32'h2);
      @(posedge clk);
      #1;
      req_v[0] = 8'h03;
      @(negedge clk);
      chk("lit_drop_next", 0, 32'(gnt_o[0]), 32'h1);

      // Full stall: nothing granted, stall counted, grant resumes afterwards.
      do_reset();
      req_v[1]  = 8'h02;
      full_v[1] = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("lit_stall_gnt", 1, 32'(gnt_o[1]), 32'h0);
         chk("lit_stall_wren", 1, 32'(wren_o[1]), 32'h0);
      end
      @(posedge clk);
      #1;
      full_v[1] = 1'b0;
      @(negedge clk);
      chk("lit_stall_cnt", 1, 32'(stl_o[1]), 32'd5);
      chk("lit_stall_resume", 1, 32'(gnt_o[1]), 32'h2);

      // Full in the middle of a burst keeps the burst count.
      @(posedge clk);
      #1;
      req_v[1] = 8'h0;
      req_v[0] = 8'h06;
      @(negedge clk);
      chk("lit_mid_first", 0, 32'(gnt_o[0]), 32'h2);
      @(posedge clk);
      #1;
      full_v[0] = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("lit_mid_stall", 0, 32'(gnt_o[0]), 32'h0);
      end
      @(posedge clk);
      #1;
      full_v[0] = 1'b0;
      @(negedge clk);
      chk("lit_mid_resume", 0, 32'(gnt_o[0]), 32'h2);
      chk("lit_mid_cnt", 0, 32'(stl_o[0]), 32'd3);
      @(negedge clk);
      chk("lit_mid_next", 0, 32'(gnt_o[0]), 32'h4);

      // Stall counter saturation.
      do_reset();
      req_v[0]  = 8'h01;
      full_v[0] = 1'b1;
      req_v[2]  = 8'h01;
      full_v[2] = 1'b1;
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("lit_sat4", 0, 32'(stl_o[0]), 32'd15);
      chk("lit_sat5", 2, 32'(stl_o[2]), 32'd20);

      // Asynchronous reset in the middle of a burst owned by requester 2.
      @(posedge clk);
      #1;
      full_v[0] = 1'b0;
      full_v[2] = 1'b0;
      req_v[2]  = 8'h0;
      req_v[0]  = 8'h04;
      @(negedge clk);
      chk("lit_ar_first", 0, 32'(gnt_o[0]), 32'h4);
      @(posedge clk);
      #2;
      chk("lit_ar_owner", 0, 32'(own_o[0]), 32'd2);
      chk("lit_ar_second", 0, 32'(gnt_o[0]), 32'h4);
      #1;
      rst_n = 1'b0;
      #1;
      chk("lit_ar_gnt", 0, 32'(gnt_o[0]), 32'h0);
      chk("lit_ar_wren", 0, 32'(wren_o[0]), 32'h0);
      chk("lit_ar_datain", 0, 32'(din_o[0]), 32'h0);
      chk("lit_ar_owner0", 0, 32'(own_o[0]), 32'h0);
      chk("lit_ar_stall0", 0, 32'(stl_o[0]), 32'h0);
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      req_v[0] = 8'h0F;
      @(negedge clk);
      chk("lit_ar_restart", 0, 32'(gnt_o[0]), 32'h1);

      // Randomized traffic; requests are held until granted, then renewed.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge clk);
         #1;
         if (cyc % 600 == 599) begin
            #2;
            rst_n = 1'b0;
            @(posedge clk);
            #1;
            rst_n = 1'b1;
         end
         dens  = ((cyc / 500) % 3 == 0) ? 40 : (((cyc / 500) % 3 == 1) ? 75 : 100);
         fullp = ((cyc / 300) % 3 == 0) ? 0 : (((cyc / 300) % 3 == 1) ? 25 : 60);
         for (int k = 0; k < NI; k++) begin
            full_v[k] = ($urandom_range(99) < fullp);
            for (int i = 0; i < n_of(k); i++) begin
               if (!req_v[k][i] || last_gnt[k][i]) begin
                  req_v[k][i] = ($urandom_range(99) < dens);
                  dat[k][i]   = W'($urandom);
               end
            end
         end
      end
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write-port arbiter that shares the write side of the FIFO/LIFO buffer among NREQ producers. It accepts per-requester valid/data, picks one winner per cycle, and drives the buffer's Wren/Datain with the winner's word. Full gates all grants. Optional burst lock lets a winner keep the port for up to BURST consecutive words. It sits between the producers and the buffer's write port, and runs on the buffer's write clock.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 32, data word width; matches the buffer Datain
BURST, 2, max consecutive grants to one owner before the pointer is forced on (1 = pure round-robin)
CNTW, 16, width of the stall counter

Ports:
Clk  input  1  write-domain clock; same clock as the buffer Wrclk
Rst  input  1  asynchronous, active-low reset
Req  input  NREQ  per-requester write request; level, held until granted
Reqdata  input  NREQ*WIDTH  packed data; requester i occupies bits [i*WIDTH +: WIDTH]
Full  input  1  buffer full flag
Gnt  output  NREQ  one-hot; Gnt[i]=1 means the word is consumed this cycle
Wren  output  1  buffer write enable
Datain  output  WIDTH  buffer write data
Owner  output  clog2(NREQ)  index of the last granted requester (registered)
Stallcnt  output  CNTW  saturating count of cycles with Req!=0 and Full=1

Behaviour:
- Grant path is combinational, in the same cycle as Req/Full. State updates on posedge Clk. This gives zero-latency acceptance, so a registered Full can never be overrun.
- Rst low (async): ptr=0, state=IDLE, burst count=0, Owner=0, Stallcnt=0. While Rst is low, Gnt=0, Wren=0, Datain=0 regardless of Req.
- Wren = |Gnt. Datain = Reqdata slice of the granted index, else 0. Gnt is never multi-hot.
- Full=1: Gnt=0, Wren=0. ptr, state and burst count hold. Stallcnt increments if Req!=0 and saturates at all-ones.
- Full=0 and Req=0: no grant. State goes to IDLE and burst count clears; ptr holds.
- State IDLE:
  - Winner = first i with Req[i]=1, scanning ptr, ptr+1, ... modulo NREQ.
  - On grant: Owner<=winner, burst count<=1.
  - If BURST>1: state<=LOCK, ptr<=winner.
  - If BURST==1: ptr<=winner+1 (mod NREQ), state stays IDLE.
- State LOCK:
  - If Req[Owner]=1 and burst count<BURST: grant Owner, burst count++.
  - When burst count reaches BURST on that grant: ptr<=Owner+1, state<=IDLE.
  - If Req[Owner]=0: lock drops the same cycle. ptr<=Owner+1, then IDLE arbitration runs combinationally in that cycle from the new pointer value. The same-cycle grant to another requester is allowed.
- After a forced pointer move, the former owner can win again only if no other Req is set. It then starts a fresh burst.
- Wrap-around: ptr increments modulo NREQ. When NREQ is not a power of two, index NREQ-1 wraps to 0.
- Full asserting mid-burst: LOCK and burst count are preserved. The burst resumes when Full drops, if Req[Owner] is still set.
- Reset mid-burst: all state clears immediately. No partial word is written, because Wren is forced low.

Decomposition:
- Package fifo_arb_pkg holds:
  - state enum: IDLE=1'b0, LOCK=1'b1
  - function clog2
  - PTRW localparam helper
- One natural sub-module: rr_pick. It is a combinational rotate-priority encoder with inputs req[NREQ] and ptr, and outputs onehot[NREQ], idx and any. It is instantiated once.
- Counters and the FSM live in fifo_wr_arbiter.

Test Plan:
1. NREQ=4, BURST=1, Req=4'b1111, Full=0 for 8 cycles -> Gnt sequence 0001,0010,0100,1000,0001,... Each cycle Datain equals that requester's word and Wren=1.
2. BURST=2, Req=4'b0101 held -> Gnt 0001,0001,0100,0100,0001,0001. Owner follows 0,0,2,2,0,0.
3. BURST=2, Req=4'b0011; drop Req[0] after its first grant -> next cycle Gnt=0010 (same-cycle handover). ptr then advances past 1 after requester 1's burst.
4. Req=4'b0010, Full=1 for 5 cycles, then Full=0 -> Gnt=0 and Wren=0 for 5 cycles, Stallcnt=5, then Gnt=0010. Burst state is preserved across the stall.
5. CNTW=4, Full=1 with Req!=0 for 20 cycles -> Stallcnt saturates at 15 and holds.
6. Rst pulled low mid-burst (Owner=2, count=1) -> Gnt/Wren drop asynchronously and Owner/Stallcnt read 0. After release with Req=4'b1111, the first Gnt is 0001.
